// File: rtl/button_conditioner_pkg.sv
// Shared constants for the button conditioner: button index map, default
// channel count, default debounce window and debounce counter width.
package button_conditioner_pkg;

   localparam int BTN_SEL1  = 0;
   localparam int BTN_CONF1 = 1;
   localparam int BTN_SEL2  = 2;
   localparam int BTN_CONF2 = 3;
   localparam int BTN_START = 4;

   localparam int N_BTN_DEF     = 5;
   localparam int DB_CYCLES_DEF = 1000000;
   localparam int CNT_W         = 20;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One conditioned input: 2-flop synchronizer, stability counter, debounced
// level and registered rise/fall pulses.
module debounce_channel
   import button_conditioner_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic lvl,
   output logic press,
   output logic rel
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic             stable;
   logic [CNT_W-1:0] cnt;
   logic             done;

   // The window closes when the synchronized value has differed for DB_CYCLES edges.
   assign done = (sync_p1 != stable) && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         stable  <= 1'b0;
         cnt     <= '0;
         press   <= 1'b0;
         rel     <= 1'b0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         press   <= done &  sync_p1;
         rel     <= done & ~sync_p1;
         if ((sync_p1 == stable) || done)
            cnt <= '0;
         else
            cnt <= cnt + CNT_W'(1);
         if (done)
            stable <= sync_p1;
      end
   end

   assign lvl = stable;

endmodule

// File: rtl/button_conditioner.sv
// Debounces the push buttons and the mode switch feeding the game top level;
// buttons yield level plus press/release pulses, mode yields a level only.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF,
   parameter int N_BTN     = N_BTN_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic             mode_raw,
   output logic [N_BTN-1:0] btn_lvl,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic             mode_lvl
);

   logic mode_press_unused;
   logic mode_release_unused;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_ch (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (btn_raw[i]),
         .lvl   (btn_lvl[i]),
         .press (btn_press[i]),
         .rel   (btn_release[i])
      );
   end

   // The mode switch is consumed as a level, so its edge pulses go nowhere.
   debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_mode (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (mode_raw),
      .lvl   (mode_lvl),
      .press (mode_press_unused),
      .rel   (mode_release_unused)
   );

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: windowed reference model feeding a scoreboard,
// directed timing scenarios, then randomized bouncing with random resets.
module tb_button_conditioner;

   localparam int NB = 5;
   localparam int DB = 16;
   localparam int NC = NB + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NB-1:0] btn_raw;
   logic          mode_raw;
   logic [NB-1:0] btn_lvl;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;
   logic          mode_lvl;

   button_conditioner #(.DB_CYCLES(DB), .N_BTN(NB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw),
      .mode_raw    (mode_raw),
      .btn_lvl     (btn_lvl),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .mode_lvl    (mode_lvl)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NB-1:0] lvl;
      logic [NB-1:0] press;
      logic [NB-1:0] rel;
      logic          mode;
   } exp_t;

   exp_t expq[$];
   int   vectors    = 0;
   int   miscompares = 0;

   // Reference model: a channel's level flips once the last DB values seen
   // behind a two-sample delay all disagree with the current level.
   bit d1[NC];
   bit d2[NC];
   bit st[NC];
   bit hist[NC][$];

   initial begin
      for (int c = 0; c < NC; c++) begin
         d1[c] = 0; d2[c] = 0; st[c] = 0;
      end
      forever begin
         exp_t ex;
         @(posedge clk);
         ex = '0;
         if (rst_n !== 1'b1) begin
            for (int c = 0; c < NC; c++) begin
               d1[c] = 0; d2[c] = 0; st[c] = 0;
               hist[c].delete();
            end
         end else begin
            for (int c = 0; c < NC; c++) begin
               bit r, y, flip;
               r = (c < NB) ? btn_raw[c] : mode_raw;
               y = d2[c];
               d2[c] = d1[c];
               d1[c] = r;
               hist[c].push_back(y);
               if (hist[c].size() > DB) void'(hist[c].pop_front());
               flip = (hist[c].size() == DB);
               foreach (hist[c][k]) if (hist[c][k] == st[c]) flip = 0;
               if (flip) begin
                  st[c] = y;
                  if (c < NB) begin
                     if (y) ex.press[c] = 1'b1;
                     else   ex.rel[c]   = 1'b1;
                  end
               end
               if (c < NB) ex.lvl[c] = st[c];
               else        ex.mode   = st[c];
            end
         end
         expq.push_back(ex);
      end
   end

   // Monitor: the DUT presents a full output word every cycle.
   initial begin
      forever begin
         exp_t ex, got;
         @(posedge clk);
         #1;
         if (expq.size() == 0) continue;
         ex  = expq.pop_front();
         got = {btn_lvl, btn_press, btn_release, mode_lvl};
         vectors++;
         if (got !== ex) begin
            miscompares++;
            $display("FAIL scoreboard t=%0t got lvl=%b press=%b rel=%b mode=%b expected lvl=%b press=%b rel=%b mode=%b",
                     $time, got.lvl, got.press, got.rel, got.mode, ex.lvl, ex.press, ex.rel, ex.mode);
         end
         vectors++;
         if ((btn_press & btn_release) !== '0) begin
            miscompares++;
            $display("FAIL press_and_release t=%0t press=%b release=%b required no overlap",
                     $time, btn_press, btn_release);
         end
      end
   end

   task automatic check(input string name, input int got, input int req);
      vectors++;
      if (got !== req) begin
         miscompares++;
         $display("FAIL %s got=%0d required=%0d", name, got, req);
      end
   endtask

   task automatic check_zero(input string name);
      check(name, int'({btn_lvl, btn_press, btn_release, mode_lvl}), 0);
   endtask

   // kind 0: btn_press[b], 1: btn_release[b], 2: mode_lvl. Edge 1 is the first
   // rising edge after the call.
   task automatic watch(input int ncyc, input int kind, input int b,
                        output int first, output int count);
      first = -1;
      count = 0;
      for (int e = 1; e <= ncyc; e++) begin
         logic s;
         @(posedge clk);
         #1;
         s = (kind == 0) ? btn_press[b] : (kind == 1) ? btn_release[b] : mode_lvl;
         if (s === 1'b1) begin
            count++;
            if (first < 0) first = e;
         end
      end
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int first, count, bounce, pe, re, pv;
      rst_n    = 1'b0;
      btn_raw  = '0;
      mode_raw = 1'b0;
      settle(3);
      check_zero("reset_state");

      // Held button from reset release: one press after edge 18, no repeats.
      rst_n      = 1'b1;
      btn_raw[0] = 1'b1;
      watch(200, 0, 0, first, count);
      check("held_press_edge", first, DB + 2);
      check("held_press_count", count, 1);
      check("held_lvl", int'(btn_lvl[0]), 1);
      @(negedge clk);
      btn_raw[0] = 1'b0;
      settle(25);

      // Bouncing faster than the window never produces a pulse.
      bounce = 0;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (t % 5 == 0) btn_raw[1] = ~btn_raw[1];
         @(posedge clk);
         #1;
         if (btn_press[1] || btn_release[1]) bounce++;
      end
      @(negedge clk);
      btn_raw[1] = 1'b1;
      watch(40, 0, 1, first, count);
      check("bounce_pulses", bounce, 0);
      check("bounce_press_edge", first, DB + 2);
      check("bounce_press_count", count, 1);
      @(negedge clk);
      btn_raw = '0;
      settle(25);

      // Simultaneous edges on several buttons.
      @(negedge clk);
      btn_raw = 5'b10101;
      first = -1;
      pv    = 0;
      for (int e = 1; e <= 30; e++) begin
         @(posedge clk);
         #1;
         if (first < 0 && btn_press != '0) begin
            first = e;
            pv    = int'(btn_press);
         end
      end
      check("multi_press_edge", first, DB + 2);
      check("multi_press_value", pv, 5'b10101);
      @(negedge clk);
      btn_raw = '0;
      settle(25);

      // Press held 40 cycles then released.
      @(negedge clk);
      btn_raw[3] = 1'b1;
      pe = -1;
      re = -1;
      for (int e = 1; e <= 80; e++) begin
         @(posedge clk);
         #1;
         if (btn_press[3] && pe < 0)   pe = e;
         if (btn_release[3] && re < 0) re = e;
         if (e == 40) begin
            @(negedge clk);
            btn_raw[3] = 1'b0;
         end
      end
      check("hold_press_edge", pe, DB + 2);
      check("hold_release_gap", re - pe, 40);
      settle(5);

      // Reset in the middle of a debounce window.
      btn_raw[4] = 1'b1;
      settle(25);
      btn_raw[2] = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero("midreset_outputs");
      @(negedge clk);
      rst_n = 1'b1;
      watch(40, 0, 2, first, count);
      check("midreset_press_edge", first, DB + 2);
      check("midreset_press_count", count, 1);
      @(negedge clk);
      btn_raw = '0;
      settle(25);

      // Mode switch produces a level only.
      @(negedge clk);
      mode_raw = 1'b1;
      watch(30, 2, 0, first, count);
      check("mode_rise_edge", first, DB + 2);
      check("mode_btn_lvl", int'(btn_lvl), 0);
      settle(5);

      // Randomized bouncing with calm phases and occasional resets.
      for (int i = 0; i < 4000; i++) begin
         int lim;
         @(negedge clk);
         lim = ((i / 400) % 2 == 1) ? 3 : 59;
         for (int b = 0; b < NB; b++)
            if ($urandom_range(lim) == 0) btn_raw[b] = ~btn_raw[b];
         if ($urandom_range(lim) == 0) mode_raw = ~mode_raw;
         rst_n = ($urandom_range(699) == 0) ? 1'b0 : 1'b1;
      end
      @(negedge clk);
      rst_n = 1'b1;
      settle(40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
